// File: rtl/serial_audio_encoder_pkg.sv
// Shared constants and helpers for the serial audio encoder/decoder pair.
// Frame timing is derived from a 7-bit cycle counter: two clk per sclk, 32 bits per slot.
package serial_audio_encoder_pkg;

    localparam int SLOT_BITS   = 32;
    localparam int FRAME_CNT_W = 7;
    localparam int LOAD_PHASE  = 62;
    localparam int BIT_W       = 5;

    typedef logic [SLOT_BITS-1:0] sample_t;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    // Word-clock level for a slot; I2S is fixed low-left, left-justified follows the polarity pin.
    function automatic logic lr_level(logic is_i2s, logic pol, slot_e slot);
        if (is_i2s)
            return (slot == SLOT_RIGHT);
        return (slot == SLOT_LEFT) ? pol : ~pol;
    endfunction

endpackage

// File: rtl/serial_audio_encoder_if.sv
// Upstream sample handshake into the serial audio encoder.
interface serial_audio_encoder_if;

    logic                             i_valid;
    logic                             i_ready;
    logic                             i_is_left;
    serial_audio_encoder_pkg::sample_t i_audio;

    modport master (output i_valid, output i_is_left, output i_audio, input  i_ready);
    modport slave  (input  i_valid, input  i_is_left, input  i_audio, output i_ready);

endinterface

// File: rtl/serial_audio_clock_gen.sv
// Free-running frame counter: sclk phase, slot/bit decode and the word-load strobe.
module serial_audio_clock_gen
    import serial_audio_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    output logic             sclk_o,
    output logic             load_o,
    output logic             upd_o,
    output slot_e            slot_o,
    output slot_e            nxt_slot_o,
    output logic [BIT_W-1:0] nxt_bit_o
);

    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    // Serial outputs move on the edge where the counter becomes even (sclk falling),
    // so their next values are decoded from cnt_d rather than cnt_q.
    assign sclk_o     = cnt_q[0];
    assign load_o     = (cnt_q[FRAME_CNT_W-2:0] == (FRAME_CNT_W-1)'(LOAD_PHASE));
    assign upd_o      = ~cnt_d[0];
    assign slot_o     = slot_e'(cnt_q[FRAME_CNT_W-1]);
    assign nxt_slot_o = slot_e'(cnt_d[FRAME_CNT_W-1]);
    assign nxt_bit_o  = cnt_d[FRAME_CNT_W-2:1];

endmodule

// File: rtl/serial_audio_encoder.sv
// Serialises 32-bit stereo samples onto an I2S or left-justified bit stream.
// One word is taken per slot, just before the slot starts; missing or wrong-channel words send zeros.
module serial_audio_encoder
    import serial_audio_encoder_pkg::*;
(
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         is_i2s,
    input  logic                         lrclk_polarity,
    serial_audio_encoder_if.slave        up,
    output logic                         sclk,
    output logic                         lrclk,
    output logic                         sdout,
    output logic                         is_error,
    output logic                         is_underrun
);

    logic             load, upd;
    slot_e            slot, nxt_slot;
    logic [BIT_W-1:0] nxt_bit, idx;
    logic             xfer, match;

    sample_t hold_q, hold_d;
    logic    dly_q, dly_d;
    logic    lrclk_q, lrclk_d;
    logic    sdout_q, sdout_d;
    logic    err_q, err_d;
    logic    und_q, und_d;

    serial_audio_clock_gen u_clk_gen (
        .clk        (clk),
        .nreset     (nreset),
        .sclk_o     (sclk),
        .load_o     (load),
        .upd_o      (upd),
        .slot_o     (slot),
        .nxt_slot_o (nxt_slot),
        .nxt_bit_o  (nxt_bit)
    );

    assign up.i_ready = load;
    assign xfer       = up.i_valid & load;
    // The load lands at the end of a slot, so the target is the opposite channel.
    assign match      = (up.i_is_left == (slot == SLOT_RIGHT));

    // I2S shifts the word one bit late: bit b carries H[32-b], bit 0 carries the saved LSB.
    assign idx = is_i2s ? ~(nxt_bit - 5'd1) : ~nxt_bit;

    always_comb begin
        hold_d  = hold_q;
        dly_d   = dly_q;
        lrclk_d = lrclk_q;
        sdout_d = sdout_q;
        err_d   = 1'b0;
        und_d   = 1'b0;
        if (load) begin
            hold_d = (xfer && match) ? up.i_audio : '0;
            dly_d  = hold_q[0];
            err_d  = xfer && !match;
            und_d  = !xfer;
        end
        if (upd) begin
            lrclk_d = lr_level(is_i2s, lrclk_polarity, nxt_slot);
            sdout_d = (is_i2s && nxt_bit == '0) ? dly_q : hold_q[idx];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hold_q  <= '0;
            dly_q   <= 1'b0;
            lrclk_q <= 1'b0;
            sdout_q <= 1'b0;
            err_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            dly_q   <= dly_d;
            lrclk_q <= lrclk_d;
            sdout_q <= sdout_d;
            err_q   <= err_d;
            und_q   <= und_d;
        end
    end

    assign lrclk       = lrclk_q;
    assign sdout       = sdout_q;
    assign is_error    = err_q;
    assign is_underrun = und_q;

endmodule

// File: tb/tb_serial_audio_encoder.sv
// Randomised bench: expected wire bits come from a per-slot word table and the framing rules.
module tb_serial_audio_encoder;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic is_i2s = 1'b0;
    logic lrclk_polarity = 1'b0;
    logic sclk, lrclk, sdout, is_error, is_underrun;

    serial_audio_encoder_if bus ();

    serial_audio_encoder dut (
        .clk            (clk),
        .nreset         (nreset),
        .is_i2s         (is_i2s),
        .lrclk_polarity (lrclk_polarity),
        .up             (bus.slave),
        .sclk           (sclk),
        .lrclk          (lrclk),
        .sdout          (sdout),
        .is_error       (is_error),
        .is_underrun    (is_underrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          v;
        bit          l;
        logic [31:0] d;
    } stim_t;

    stim_t dq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, want %h", tag, $time, got, exp);
        end
    endtask

    function automatic bit exp_lr(bit i2s, bit pol, int slot);
        bit left;
        left = (slot % 2 == 0);
        if (i2s) return !left;
        return left ? pol : !pol;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sclk"},  32'(sclk),        32'd0);
        chk({tag, "_lrclk"}, 32'(lrclk),       32'd0);
        chk({tag, "_sdout"}, 32'(sdout),       32'd0);
        chk({tag, "_rdy"},   32'(bus.i_ready), 32'd0);
        chk({tag, "_err"},   32'(is_error),    32'd0);
        chk({tag, "_und"},   32'(is_underrun), 32'd0);
    endtask

    // Runs nslots slots after a fresh reset; abort_at>0 pulls reset after that many clocks.
    task automatic run(input bit i2s, input bit pol, input int nslots, input int abort_at);
        logic [31:0] w [0:255];
        logic [31:0] cur, prv;
        bit          e_err, e_und, e_sd, e_lr, tgt_left;
        int          slot, ph, b;
        stim_t       s;

        nreset = 1'b0;
        is_i2s = i2s;
        lrclk_polarity = pol;
        bus.i_valid = 1'b0;
        bus.i_is_left = 1'b0;
        bus.i_audio = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        nreset = 1'b1;

        w[0] = '0;
        e_err = 1'b0;
        e_und = 1'b0;
        for (int c = 1; c <= nslots * 64; c++) begin
            @(posedge clk);
            #1;
            if (c == abort_at) begin
                nreset = 1'b0;
                #1;
                chk_all_zero("mid_rst");
                return;
            end
            slot = c / 64;
            ph   = c % 64;
            b    = ph / 2;
            cur  = w[slot];
            prv  = (slot == 0) ? 32'd0 : w[slot - 1];
            e_lr = (c < 2) ? 1'b0 : exp_lr(i2s, pol, slot);
            if (c < 2)       e_sd = 1'b0;
            else if (!i2s)   e_sd = cur[31 - b];
            else if (b == 0) e_sd = prv[0];
            else             e_sd = cur[32 - b];

            chk("sclk",   32'(sclk),        32'(c % 2));
            chk("lrclk",  32'(lrclk),       32'(e_lr));
            chk("sdout",  32'(sdout),       32'(e_sd));
            chk("ready",  32'(bus.i_ready), 32'(ph == 62));
            chk("error",  32'(is_error),    32'(e_err));
            chk("undrun", 32'(is_underrun), 32'(e_und));
            e_err = 1'b0;
            e_und = 1'b0;

            if (ph == 62) begin
                tgt_left = (slot % 2 == 1);
                if (dq.size() > 0) begin
                    s = dq.pop_front();
                end else begin
                    s.v = ($urandom_range(0, 99) < 85);
                    s.l = ($urandom_range(0, 99) < 85) ? tgt_left : !tgt_left;
                    s.d = $urandom;
                end
                bus.i_valid   = s.v;
                bus.i_is_left = s.l;
                bus.i_audio   = s.d;
                w[slot + 1]   = (s.v && s.l == tgt_left) ? s.d : 32'd0;
                e_err         = s.v && (s.l != tgt_left);
                e_und         = !s.v;
            end else begin
                // Junk offered while not ready must never be consumed.
                bus.i_valid   = 1'($urandom_range(0, 1));
                bus.i_is_left = 1'($urandom_range(0, 1));
                bus.i_audio   = $urandom;
            end
        end
    endtask

    initial begin
        // LJ, pol=1: first load targets right; then the directed pair, an idle frame,
        // a wrong-channel word for the left slot and a good right word.
        dq.push_back('{1'b1, 1'b0, 32'h7FFF_FFFE});
        dq.push_back('{1'b1, 1'b1, 32'h8000_0001});
        dq.push_back('{1'b1, 1'b0, 32'h7FFF_FFFE});
        dq.push_back('{1'b0, 1'b1, 32'h1111_1111});
        dq.push_back('{1'b0, 1'b0, 32'h2222_2222});
        dq.push_back('{1'b1, 1'b0, 32'h1234_5678});
        dq.push_back('{1'b1, 1'b0, 32'hCAFE_F00D});
        run(1'b0, 1'b1, 16, 0);

        run(1'b0, 1'b0, 12, 0);

        dq.push_back('{1'b1, 1'b0, 32'h0F0F_0F0F});
        dq.push_back('{1'b1, 1'b1, 32'hA5A5_A5A5});
        run(1'b1, 1'b0, 16, 0);

        // Reset when cnt reaches 40 in the second frame's left slot.
        run(1'b0, 1'b1, 4, 168);
        run(1'b1, 1'b1, 6, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
